csr_access_unit: RTL and testbench

- Initiator side of the CSR file's read/write port.
- Accepts one CSR micro-op (csrrd/csrwr/csrxchg) from issue and holds it until the ROB commits that instruction.
- Then performs the read-modify-write sequence on the CSR file and returns the old CSR value to register writeback.
- Sits between the issue queue / ROB commit logic and the CSR file. It has a single-entry buffer because CSR ops are serializing.

---
 rtl/csr_access_unit.sv | 167 ++++++++++++++++
 tb/tb_csr_access_unit.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// ---------------------------------------------------------------------------
// csr_access_unit
//
// Initiator side of the CSR file read/write port. Buffers one CSR micro-op
// (csrrd / csrwr / csrxchg) from issue, waits for the ROB to commit it, then
// runs a read-modify-write on the CSR file and returns the old CSR value to
// register writeback. CSR ops are serializing, so one buffer entry is enough.
//
// Ports:
//   Clk, Rest                      clock, synchronous active-low reset
//   InValid/InReady, InOp,         issue handshake and micro-op fields
//   InCsrAddr, InRdVal, InRjVal,
//   InRd, InRobTag
//   CommitValid, CommitRobTag      ROB head commit notification
//   Flush                          kills an op that has not yet committed
//   CsrRdEn/CsrRdAddr/CsrRdData    CSR read port (data one cycle after enable)
//   CsrWrEn/CsrWrAddr/CsrWrData    CSR write port (single-cycle strobe)
//   WbValid/WbReady, WbRd,         writeback handshake carrying the old value
//   WbData, WbRobTag
//   Busy                           an op is buffered or in flight
// ---------------------------------------------------------------------------
module csr_access_unit #(
   parameter int ROB_W  = 6,
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Rest,
   input  logic              InValid,
   output logic              InReady,
   input  logic [1:0]        InOp,
   input  logic [13:0]       InCsrAddr,
   input  logic [DATA_W-1:0] InRdVal,
   input  logic [DATA_W-1:0] InRjVal,
   input  logic [4:0]        InRd,
   input  logic [ROB_W-1:0]  InRobTag,
   input  logic              CommitValid,
   input  logic [ROB_W-1:0]  CommitRobTag,
   input  logic              Flush,
   output logic              CsrRdEn,
   output logic [13:0]       CsrRdAddr,
   input  logic [DATA_W-1:0] CsrRdData,
   output logic              CsrWrEn,
   output logic [13:0]       CsrWrAddr,
   output logic [DATA_W-1:0] CsrWrData,
   output logic              WbValid,
   input  logic              WbReady,
   output logic [4:0]        WbRd,
   output logic [DATA_W-1:0] WbData,
   output logic [ROB_W-1:0]  WbRobTag,
   output logic              Busy
);

   localparam logic [1:0] OP_ILLEGAL = 2'b00;
   localparam logic [1:0] OP_RD      = 2'b01;
   localparam logic [1:0] OP_WR      = 2'b10;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_CMT = 3'd1,
      READ     = 3'd2,
      LATCH    = 3'd3,
      WRITE    = 3'd4,
      RESP     = 3'd5
   } state_t;

   state_t state;
   state_t state_next;

   logic [1:0]        op;
   logic [13:0]       addr;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rj_val;
   logic [4:0]        rd;
   logic [ROB_W-1:0]  rob_tag;
   logic [DATA_W-1:0] old_val;

   logic in_accept;
   logic commit_hit;

   assign InReady    = (state == IDLE) && !Flush && Rest;
   assign in_accept  = InValid && InReady && (InOp != OP_ILLEGAL);
   assign commit_hit = CommitValid && (CommitRobTag == rob_tag);

   always_ff @(posedge Clk) begin
      if (!Rest) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Commit is checked before Flush in WAIT_CMT: once the ROB says the op
   // committed it must complete even if a flush arrives in the same cycle.
   // From READ onward the op is architecturally committed, so Flush is ignored.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_accept) begin
               state_next = WAIT_CMT;
            end
         end
         WAIT_CMT: begin
            if (commit_hit) begin
               state_next = READ;
            end else if (Flush) begin
               state_next = IDLE;
            end
         end
         READ:  state_next = LATCH;
         LATCH: state_next = WRITE;
         WRITE: state_next = RESP;
         RESP: begin
            if (WbReady) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand buffer. The old CSR value is captured in LATCH because the CSR
   // file returns read data exactly one cycle after the READ-state enable.
   always_ff @(posedge Clk) begin
      if (!Rest) begin
         op      <= '0;
         addr    <= '0;
         rd_val  <= '0;
         rj_val  <= '0;
         rd      <= '0;
         rob_tag <= '0;
         old_val <= '0;
      end else begin
         if (in_accept) begin
            op      <= InOp;
            addr    <= InCsrAddr;
            rd_val  <= InRdVal;
            rj_val  <= InRjVal;
            rd      <= InRd;
            rob_tag <= InRobTag;
         end
         if (state == LATCH) begin
            old_val <= CsrRdData;
         end
      end
   end

   // Strobes are qualified with Rest so that a reset arriving mid-operation
   // can never leak a CSR access or writeback in the reset cycle itself.
   always_comb begin
      CsrRdEn   = Rest && (state == READ);
      CsrRdAddr = addr;
      CsrWrEn   = Rest && (state == WRITE) && (op != OP_RD);
      CsrWrAddr = addr;
      if (op == OP_WR) begin
         CsrWrData = rd_val;
      end else begin
         CsrWrData = (old_val & ~rj_val) | (rd_val & rj_val);
      end
      WbValid  = Rest && (state == RESP);
      WbRd     = rd;
      WbData   = old_val;
      WbRobTag = rob_tag;
      Busy     = (state != IDLE);
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_access_unit
//
// Scoreboard bench for csr_access_unit. Expected CSR writes and writeback
// results are computed from a bench-side CSR reference image when each op is
// issued, queued, and compared when the DUT produces them. A small CSR file
// model answers the DUT read port one cycle after CsrRdEn.
// ---------------------------------------------------------------------------
module tb_csr_access_unit;

   logic        Clk;
   logic        Rest;
   logic        InValid;
   logic        InReady;
   logic [1:0]  InOp;
   logic [13:0] InCsrAddr;
   logic [31:0] InRdVal;
   logic [31:0] InRjVal;
   logic [4:0]  InRd;
   logic [5:0]  InRobTag;
   logic        CommitValid;
   logic [5:0]  CommitRobTag;
   logic        Flush;
   logic        CsrRdEn;
   logic [13:0] CsrRdAddr;
   logic [31:0] CsrRdData;
   logic        CsrWrEn;
   logic [13:0] CsrWrAddr;
   logic [31:0] CsrWrData;
   logic        WbValid;
   logic        WbReady;
   logic [4:0]  WbRd;
   logic [31:0] WbData;
   logic [5:0]  WbRobTag;
   logic        Busy;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [5:0]  tag;
   } wbExp_t;

   typedef struct {
      logic [13:0] addr;
      logic [31:0] data;
   } wrExp_t;

   wbExp_t wbQ[$];
   wrExp_t wrQ[$];
   wbExp_t wbGot;
   wrExp_t wrGot;

   logic [31:0] csrMem [0:16383];
   logic [31:0] refMem [0:16383];
   logic        loadMem;

   int total;
   int bad;

   csr_access_unit #(.ROB_W(6), .DATA_W(32)) dut (
      .Clk          (Clk),
      .Rest         (Rest),
      .InValid      (InValid),
      .InReady      (InReady),
      .InOp         (InOp),
      .InCsrAddr    (InCsrAddr),
      .InRdVal      (InRdVal),
      .InRjVal      (InRjVal),
      .InRd         (InRd),
      .InRobTag     (InRobTag),
      .CommitValid  (CommitValid),
      .CommitRobTag (CommitRobTag),
      .Flush        (Flush),
      .CsrRdEn      (CsrRdEn),
      .CsrRdAddr    (CsrRdAddr),
      .CsrRdData    (CsrRdData),
      .CsrWrEn      (CsrWrEn),
      .CsrWrAddr    (CsrWrAddr),
      .CsrWrData    (CsrWrData),
      .WbValid      (WbValid),
      .WbReady      (WbReady),
      .WbRd         (WbRd),
      .WbData       (WbData),
      .WbRobTag     (WbRobTag),
      .Busy         (Busy)
   );

   // Free-running clock, posedge at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // CSR file model: read data appears one cycle after the enable; a junk
   // pattern otherwise so a mistimed latch shows up as a data error.
   always @(posedge Clk) begin
      if (loadMem) begin
         for (int i = 0; i < 16384; i++) begin
            csrMem[i] <= 32'h0;
         end
         csrMem[14'h005] <= 32'h0000_1234;
         csrMem[14'h010] <= 32'hFFFF_0000;
         CsrRdData       <= 32'hBAD0_BAD0;
      end else begin
         if (CsrRdEn) begin
            CsrRdData <= csrMem[CsrRdAddr];
         end else begin
            CsrRdData <= 32'hBAD0_BAD0;
         end
         if (CsrWrEn) begin
            csrMem[CsrWrAddr] <= CsrWrData;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare every CSR write and writeback handshake.
   always @(negedge Clk) begin
      if (CsrWrEn) begin
         if (wrQ.size() == 0) begin
            checkOutput("unexpected_csr_write", 64'd1, 64'd0);
         end else begin
            wrGot = wrQ.pop_front();
            checkOutput("csr_wr_addr", 64'(CsrWrAddr), 64'(wrGot.addr));
            checkOutput("csr_wr_data", 64'(CsrWrData), 64'(wrGot.data));
         end
      end
      if (WbValid && WbReady) begin
         if (wbQ.size() == 0) begin
            checkOutput("unexpected_wb", 64'd1, 64'd0);
         end else begin
            wbGot = wbQ.pop_front();
            checkOutput("wb_rd",   64'(WbRd),     64'(wbGot.rd));
            checkOutput("wb_data", 64'(WbData),   64'(wbGot.data));
            checkOutput("wb_tag",  64'(WbRobTag), 64'(wbGot.tag));
         end
      end
   end

   // Expected results come from the bench's own CSR image, updated in
   // program order as each completing op is issued.
   task automatic pushExpect(input logic [1:0] op, input logic [13:0] addr,
                             input logic [31:0] rdVal, input logic [31:0] rjVal,
                             input logic [4:0] rd, input logic [5:0] tag);
      wbExp_t wbE;
      wrExp_t wrE;
      logic [31:0] oldVal;
      logic [31:0] newVal;
      oldVal = refMem[addr];
      if (op == 2'b10) begin
         newVal = rdVal;
      end else begin
         newVal = (oldVal & ~rjVal) | (rdVal & rjVal);
      end
      wbE.rd   = rd;
      wbE.data = oldVal;
      wbE.tag  = tag;
      wbQ.push_back(wbE);
      if (op != 2'b01) begin
         wrE.addr = addr;
         wrE.data = newVal;
         wrQ.push_back(wrE);
         refMem[addr] = newVal;
      end
   endtask

   // Presents one op to an idle unit; returns one cycle into WAIT_CMT.
   task automatic applyStimulus(input logic [1:0] op, input logic [13:0] addr,
                                input logic [31:0] rdVal, input logic [31:0] rjVal,
                                input logic [4:0] rd, input logic [5:0] tag);
      InValid   = 1'b1;
      InOp      = op;
      InCsrAddr = addr;
      InRdVal   = rdVal;
      InRjVal   = rjVal;
      InRd      = rd;
      InRobTag  = tag;
      @(negedge Clk);
      checkOutput("accept_inready", 64'(InReady), 64'd1);
      @(posedge Clk); #1;
      InValid = 1'b0;
      @(negedge Clk);
      checkOutput("accept_busy", 64'(Busy), 64'd1);
      @(posedge Clk); #1;
   endtask

   // Commits the buffered op and checks the C+1 / C+3 / C+4 timing.
   task automatic commitAndCheck(input logic [1:0] op, input logic [13:0] addr,
                                 input logic [5:0] tag, input int preWait,
                                 input logic flushToo);
      for (int i = 0; i < preWait; i++) begin
         CommitValid  = 1'b1;
         CommitRobTag = tag ^ 6'h01;
         @(negedge Clk);
         checkOutput("wait_no_rden", 64'(CsrRdEn), 64'd0);
         checkOutput("wait_busy",    64'(Busy),    64'd1);
         @(posedge Clk); #1;
      end
      CommitValid  = 1'b1;
      CommitRobTag = tag;
      Flush        = flushToo;
      @(posedge Clk); #1;
      CommitValid = 1'b0;
      Flush       = 1'b0;
      @(negedge Clk);
      checkOutput("c1_rden",   64'(CsrRdEn),   64'd1);
      checkOutput("c1_rdaddr", 64'(CsrRdAddr), 64'(addr));
      checkOutput("c1_wren",   64'(CsrWrEn),   64'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("c2_rden", 64'(CsrRdEn), 64'd0);
      checkOutput("c2_wren", 64'(CsrWrEn), 64'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("c3_wren",   64'(CsrWrEn), (op != 2'b01) ? 64'd1 : 64'd0);
      checkOutput("c3_rden",   64'(CsrRdEn), 64'd0);
      checkOutput("c3_wbval",  64'(WbValid), 64'd0);
      @(posedge Clk); #1;
   endtask

   // Completes the writeback handshake with WbReady already high and
   // checks the unit is idle again one cycle later.
   task automatic respondAndIdle();
      @(negedge Clk);
      checkOutput("c4_wbvalid", 64'(WbValid), 64'd1);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("post_busy",    64'(Busy),    64'd0);
      checkOutput("post_inready", 64'(InReady), 64'd1);
      checkOutput("post_wbvalid", 64'(WbValid), 64'd0);
      @(posedge Clk); #1;
   endtask

   task automatic runOp(input logic [1:0] op, input logic [13:0] addr,
                        input logic [31:0] rdVal, input logic [31:0] rjVal,
                        input logic [4:0] rd, input logic [5:0] tag,
                        input int preWait, input logic flushToo);
      pushExpect(op, addr, rdVal, rjVal, rd, tag);
      applyStimulus(op, addr, rdVal, rjVal, rd, tag);
      commitAndCheck(op, addr, tag, preWait, flushToo);
      respondAndIdle();
   endtask

   // Hard stop in case something wedges the initial block.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      total        = 0;
      bad          = 0;
      Rest         = 1'b0;
      InValid      = 1'b0;
      InOp         = 2'b00;
      InCsrAddr    = '0;
      InRdVal      = '0;
      InRjVal      = '0;
      InRd         = '0;
      InRobTag     = '0;
      CommitValid  = 1'b0;
      CommitRobTag = '0;
      Flush        = 1'b0;
      WbReady      = 1'b1;
      loadMem      = 1'b1;
      for (int i = 0; i < 16384; i++) begin
         refMem[i] = 32'h0;
      end
      refMem[14'h005] = 32'h0000_1234;
      refMem[14'h010] = 32'hFFFF_0000;

      @(posedge Clk); #1;
      loadMem = 1'b0;
      @(posedge Clk); #1;
      @(negedge Clk);
      $display("[TB] reset state");
      checkOutput("rst_busy",    64'(Busy),    64'd0);
      checkOutput("rst_inready", 64'(InReady), 64'd0);
      checkOutput("rst_rden",    64'(CsrRdEn), 64'd0);
      checkOutput("rst_wren",    64'(CsrWrEn), 64'd0);
      checkOutput("rst_wbvalid", 64'(WbValid), 64'd0);
      checkOutput("rst_wbdata",  64'(WbData),  64'd0);
      @(posedge Clk); #1;
      Rest = 1'b1;
      @(negedge Clk);
      checkOutput("idle_inready", 64'(InReady), 64'd1);
      @(posedge Clk); #1;

      $display("[TB] csrrd / csrxchg / csrwr with Rd=0");
      runOp(2'b01, 14'h005, 32'h0,         32'h0,         5'd4, 6'd3, 2, 1'b0);
      runOp(2'b11, 14'h010, 32'h1234_5678, 32'h0000_FF00, 5'd6, 6'd4, 0, 1'b0);
      runOp(2'b10, 14'h030, 32'hDEAD_BEEF, 32'h0,         5'd0, 6'd7, 1, 1'b0);

      $display("[TB] flush in WAIT_CMT with unrelated commit");
      applyStimulus(2'b10, 14'h050, 32'h5555_AAAA, 32'h0, 5'd2, 6'd5);
      CommitValid  = 1'b1;
      CommitRobTag = 6'd2;
      Flush        = 1'b1;
      @(negedge Clk);
      checkOutput("flush_inready_low", 64'(InReady), 64'd0);
      @(posedge Clk); #1;
      CommitValid = 1'b0;
      Flush       = 1'b0;
      @(negedge Clk);
      checkOutput("flush_inready", 64'(InReady), 64'd1);
      checkOutput("flush_busy",    64'(Busy),    64'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("flush_no_rden", 64'(CsrRdEn), 64'd0);
         checkOutput("flush_no_wren", 64'(CsrWrEn), 64'd0);
         @(posedge Clk); #1;
         @(negedge Clk);
      end
      @(posedge Clk); #1;

      $display("[TB] flush coincident with matching commit");
      runOp(2'b01, 14'h010, 32'h0, 32'h0, 5'd8, 6'd6, 0, 1'b1);

      $display("[TB] illegal op dropped");
      InValid = 1'b1;
      InOp    = 2'b00;
      @(posedge Clk); #1;
      InValid = 1'b0;
      @(negedge Clk);
      checkOutput("illegal_busy",    64'(Busy),    64'd0);
      checkOutput("illegal_inready", 64'(InReady), 64'd1);
      @(posedge Clk); #1;

      $display("[TB] writeback back-pressure");
      WbReady = 1'b0;
      pushExpect(2'b11, 14'h030, 32'h0000_FFFF, 32'h00FF_00FF, 5'd9, 6'd10);
      applyStimulus(2'b11, 14'h030, 32'h0000_FFFF, 32'h00FF_00FF, 5'd9, 6'd10);
      commitAndCheck(2'b11, 14'h030, 6'd10, 0, 1'b0);
      pushExpect(2'b01, 14'h030, 32'h0, 32'h0, 5'd7, 6'd11);
      InValid   = 1'b1;
      InOp      = 2'b01;
      InCsrAddr = 14'h030;
      InRdVal   = 32'h0;
      InRjVal   = 32'h0;
      InRd      = 5'd7;
      InRobTag  = 6'd11;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         checkOutput("bp_wbvalid", 64'(WbValid), 64'd1);
         checkOutput("bp_wbdata",  64'(WbData),  64'h0000_0000_DEAD_BEEF);
         checkOutput("bp_wbrd",    64'(WbRd),    64'd9);
         checkOutput("bp_inready", 64'(InReady), 64'd0);
         @(posedge Clk); #1;
      end
      WbReady = 1'b1;
      @(negedge Clk);
      checkOutput("bp_hs_inready", 64'(InReady), 64'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("bp_after_inready", 64'(InReady), 64'd1);
      checkOutput("bp_after_busy",    64'(Busy),    64'd0);
      @(posedge Clk); #1;
      InValid = 1'b0;
      @(negedge Clk);
      checkOutput("bp_second_busy", 64'(Busy), 64'd1);
      @(posedge Clk); #1;
      commitAndCheck(2'b01, 14'h030, 6'd11, 0, 1'b0);
      respondAndIdle();

      $display("[TB] reset during LATCH");
      applyStimulus(2'b10, 14'h040, 32'hAAAA_5555, 32'h0, 5'd3, 6'd12);
      CommitValid  = 1'b1;
      CommitRobTag = 6'd12;
      @(posedge Clk); #1;
      CommitValid = 1'b0;
      @(posedge Clk); #1;
      Rest = 1'b0;
      @(negedge Clk);
      checkOutput("rstl_wren",    64'(CsrWrEn), 64'd0);
      checkOutput("rstl_inready", 64'(InReady), 64'd0);
      @(posedge Clk); #1;
      Rest = 1'b1;
      @(negedge Clk);
      checkOutput("rstl_busy",    64'(Busy),    64'd0);
      checkOutput("rstl_wbvalid", 64'(WbValid), 64'd0);
      checkOutput("rstl_wbdata",  64'(WbData),  64'd0);
      checkOutput("rstl_wbrd",    64'(WbRd),    64'd0);
      checkOutput("rstl_inready2", 64'(InReady), 64'd1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("rstl_no_wren", 64'(CsrWrEn), 64'd0);
         @(posedge Clk); #1;
         @(negedge Clk);
      end
      @(posedge Clk); #1;
      runOp(2'b01, 14'h040, 32'h0, 32'h0, 5'd1, 6'd13, 0, 1'b0);

      checkOutput("wb_queue_empty", 64'(wbQ.size()), 64'd0);
      checkOutput("wr_queue_empty", 64'(wrQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
